// File: rtl/router_out_fifo.sv
// router_out_fifo: per-destination output FIFO of a packet router with packet-aware data_out and stall timeout
//   clock       rising-edge clock
//   resetn      asynchronous active-low reset
//   write_enb   push {lfd_state, data_in} this cycle
//   data_in     byte to store
//   lfd_state   marks data_in as a packet header byte
//   read_enb    pop request from the destination
//   data_out    registered byte, valid the cycle after an accepted pop
//   vld_out     FIFO holds at least one entry
//   full        occupancy equals DEPTH
//   empty       occupancy equals zero
//   soft_reset  one-cycle pulse when valid data sat unread for TIMEOUT cycles
module router_out_fifo #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       write_enb,
  input  logic [7:0] data_in,
  input  logic       lfd_state,
  input  logic       read_enb,
  output logic [7:0] data_out,
  output logic       vld_out,
  output logic       full,
  output logic       empty,
  output logic       soft_reset
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [6:0]    bcnt;
  logic [TW-1:0] tcnt;
  logic [8:0]    head;
  logic          rd_acc, wr_acc, hdr, tick, expire;
  assign full   = count == (AW+1)'(DEPTH);
  assign empty  = count == '0;
  assign vld_out = ~empty;
  assign head   = mem[rd_ptr];
  assign rd_acc = read_enb & ~empty;
  // at full a write is only legal when the slot under rd_ptr is freed on the same edge
  assign wr_acc = write_enb & (~full | rd_acc) & ~soft_reset;
  assign hdr    = rd_acc & head[8];
  assign tick   = vld_out & ~read_enb;
  assign expire = tick && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clock)
    if (wr_acc) mem[wr_ptr] <= {lfd_state, data_in};
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      bcnt       <= '0;
      tcnt       <= '0;
      data_out   <= 8'h00;
      soft_reset <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      bcnt       <= '0;
      tcnt       <= '0;
      data_out   <= 8'h00;
      soft_reset <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(wr_acc);
      rd_ptr     <= rd_ptr + AW'(rd_acc);
      count      <= count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
      // header length field counts payload bytes; +1 covers the trailing parity byte
      bcnt       <= hdr ? {1'b0, head[7:2]} + 7'd1 : (rd_acc && bcnt != '0) ? bcnt - 7'd1 : bcnt;
      // between packets the line idles at zero
      data_out   <= hdr ? head[7:0] : bcnt == '0 ? 8'h00 : rd_acc ? head[7:0] : data_out;
      tcnt       <= (!tick || expire) ? '0 : tcnt + TW'(1);
      soft_reset <= expire;
    end
endmodule

// File: tb/tb_router_out_fifo.sv
// tb_router_out_fifo: directed stimulus with a queue-based scoreboard for router_out_fifo
module tb_router_out_fifo;
  logic       clock = 1'b0, resetn = 1'b0, write_enb = 1'b0, lfd_state = 1'b0, read_enb = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       vld_out, full, empty, soft_reset, fire;
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  router_out_fifo #(.DEPTH(16), .TIMEOUT(30)) dut (
    .clock(clock), .resetn(resetn), .write_enb(write_enb), .data_in(data_in),
    .lfd_state(lfd_state), .read_enb(read_enb), .data_out(data_out),
    .vld_out(vld_out), .full(full), .empty(empty), .soft_reset(soft_reset)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic cyc(input logic we, input logic [7:0] d, input logic l, input logic re);
    write_enb = we;
    data_in = d;
    lfd_state = l;
    read_enb = re;
    @(negedge clock);
    write_enb = 1'b0;
    lfd_state = 1'b0;
    read_enb = 1'b0;
  endtask
  task automatic wr(input logic [7:0] d, input logic l);
    cyc(1'b1, d, l, 1'b0);
  endtask
  task automatic rd(input logic [7:0] e);
    exp_q.push_back(e);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
  endtask
  task automatic rw(input logic [7:0] d, input logic l, input logic [7:0] e);
    exp_q.push_back(e);
    cyc(1'b1, d, l, 1'b1);
  endtask
  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
  endtask
  task automatic small_packet();
    wr(8'h0C, 1'b1);
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    wr(8'h33, 1'b0);
    wr(8'h5A, 1'b0);
    rd(8'h0C);
    rd(8'h11);
    rd(8'h22);
    rd(8'h33);
    rd(8'h5A);
    chk1("pkt_empty", empty, 1'b1);
    chk1("pkt_vld", vld_out, 1'b0);
    idle();
    chk("pkt_idle_zero", data_out, 8'h00);
  endtask
  initial forever begin
    @(negedge clock);
    #2;
    fire = read_enb & vld_out & resetn;
    @(posedge clock);
    #1;
    if (fire) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop: unexpected pop, data_out %h with nothing expected", data_out);
      end else chk("pop", data_out, exp_q.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clock);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", full, 1'b0);
    chk1("rst_vld", vld_out, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk1("rst_soft", soft_reset, 1'b0);
    resetn = 1'b1;
    small_packet();
    wr(8'h38, 1'b1);
    for (int i = 1; i < 16; i++) wr(8'(8'h40 + i), 1'b0);
    chk1("fill_full", full, 1'b1);
    wr(8'hEE, 1'b0);
    chk1("drop_full", full, 1'b1);
    rd(8'h38);
    for (int i = 1; i < 16; i++) rd(8'(8'h40 + i));
    chk1("wrap_empty", empty, 1'b1);
    wr(8'h38, 1'b1);
    for (int i = 1; i < 16; i++) wr(8'(8'h60 + i), 1'b0);
    chk1("rw_full0", full, 1'b1);
    rw(8'h08, 1'b1, 8'h38);
    chk1("rw_full1", full, 1'b1);
    rw(8'hA1, 1'b0, 8'h61);
    chk1("rw_full2", full, 1'b1);
    rw(8'hA2, 1'b0, 8'h62);
    chk1("rw_full3", full, 1'b1);
    rw(8'hA3, 1'b0, 8'h63);
    chk1("rw_full4", full, 1'b1);
    for (int i = 4; i < 16; i++) rd(8'(8'h60 + i));
    rd(8'h08);
    rd(8'hA1);
    rd(8'hA2);
    rd(8'hA3);
    chk1("rw_empty", empty, 1'b1);
    do_reset();
    wr(8'h0C, 1'b1);
    wr(8'h11, 1'b0);
    rd(8'h0C);
    rd(8'h11);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("uflow_hold1", data_out, 8'h11);
    chk1("uflow_empty", empty, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("uflow_hold2", data_out, 8'h11);
    wr(8'h22, 1'b0);
    rd(8'h22);
    wr(8'h33, 1'b0);
    rd(8'h33);
    wr(8'h5A, 1'b0);
    rd(8'h5A);
    idle();
    chk("uflow_idle", data_out, 8'h00);
    do_reset();
    wr(8'h0C, 1'b1);
    wr(8'h11, 1'b0);
    rd(8'h0C);
    for (int i = 1; i <= 30; i++) begin
      idle();
      chk1("tmo_pulse", soft_reset, i == 30);
    end
    chk("tmo_hold", data_out, 8'h0C);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk1("flush_soft", soft_reset, 1'b0);
    chk1("flush_empty", empty, 1'b1);
    chk1("flush_vld", vld_out, 1'b0);
    chk("flush_data", data_out, 8'h00);
    idle();
    chk1("flush_drop", empty, 1'b1);
    do_reset();
    wr(8'hAA, 1'b0);
    wr(8'hBB, 1'b0);
    for (int i = 2; i <= 28; i++) begin
      idle();
      chk1("tmo_pre", soft_reset, 1'b0);
    end
    rd(8'h00);
    for (int i = 1; i <= 30; i++) begin
      idle();
      chk1("tmo_rearm", soft_reset, i == 30);
    end
    idle();
    chk1("tmo_rearm_empty", empty, 1'b1);
    do_reset();
    wr(8'h14, 1'b1);
    for (int i = 1; i < 7; i++) wr(8'(8'hB0 + i), 1'b0);
    wr(8'hC7, 1'b0);
    rd(8'h14);
    chk1("mid_vld", vld_out, 1'b1);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_data", data_out, 8'h00);
    chk1("arst_empty", empty, 1'b1);
    chk1("arst_vld", vld_out, 1'b0);
    chk1("arst_full", full, 1'b0);
    chk1("arst_soft", soft_reset, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    chk1("rel_empty", empty, 1'b1);
    small_packet();
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
